// File: rtl/regfile_2w_scoreboard.sv
// Two-write / two-read register file with a per-register busy scoreboard.
// Optional build macro REGFILE_ZERO_REG_EN hardwires register 0 to zero.

module regfile_2w_scoreboard_rport #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int BYPASS = 1
) (
  input  logic [ADDR_W-1:0]                     raddr,
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]    regs,
  input  logic [(1<<ADDR_W)-1:0]                busy,
  input  logic                                  wa_en,
  input  logic [ADDR_W-1:0]                     waddr_a,
  input  logic [DATA_W-1:0]                     wdata_a,
  input  logic                                  wb_en,
  input  logic [ADDR_W-1:0]                     waddr_b,
  input  logic [DATA_W-1:0]                     wdata_b,
  output logic [DATA_W-1:0]                     rdata,
  output logic                                  rbusy
);
  // Port B is checked first so forwarding matches write priority.
  always_comb begin
    rdata = regs[raddr];
    if (BYPASS != 0) begin
      if (wb_en && waddr_b == raddr)      rdata = wdata_b;
      else if (wa_en && waddr_a == raddr) rdata = wdata_a;
    end
  end

  assign rbusy = busy[raddr];
endmodule

module regfile_2w_scoreboard #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     we_a,
  input  logic [ADDR_W-1:0]        waddr_a,
  input  logic [DATA_W-1:0]        wdata_a,
  input  logic                     we_b,
  input  logic [ADDR_W-1:0]        waddr_b,
  input  logic [DATA_W-1:0]        wdata_b,
  input  logic [ADDR_W-1:0]        raddr1,
  input  logic [ADDR_W-1:0]        raddr2,
  output logic [DATA_W-1:0]        rdata1,
  output logic [DATA_W-1:0]        rdata2,
  output logic                     rbusy1,
  output logic                     rbusy2,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     rsv_ok,
  output logic [(1<<ADDR_W)-1:0]   busy_vec
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NUM_RD = 2;
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic [DEPTH-1:0]             busy;
  wr_req_t                      wr_a, wr_b;
  logic                         rsv_zero;

  // Writes aimed at a hardwired-zero register are dropped before they reach
  // storage or the bypass path.
  assign wr_a = '{en: we_a && !(ZERO_REG && waddr_a == '0), addr: waddr_a, data: wdata_a};
  assign wr_b = '{en: we_b && !(ZERO_REG && waddr_b == '0), addr: waddr_b, data: wdata_b};

  assign rsv_zero = ZERO_REG && (rsv_addr == '0);
  assign rsv_ok   = rsv_en && (rsv_zero || !busy[rsv_addr] || (we_b && waddr_b == rsv_addr));
  assign busy_vec = busy;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      regs <= '0;
      busy <= '0;
    end else begin
      if (wr_a.en) regs[wr_a.addr] <= wr_a.data;
      if (wr_b.en) regs[wr_b.addr] <= wr_b.data;   // later assignment: B wins
      if (wr_b.en) busy[wr_b.addr] <= 1'b0;
      if (rsv_ok && !rsv_zero) busy[rsv_addr] <= 1'b1; // new owner beats release
    end
  end

  logic [NUM_RD-1:0][ADDR_W-1:0] raddr_v;
  logic [NUM_RD-1:0][DATA_W-1:0] rdata_v;
  logic [NUM_RD-1:0]             rbusy_v;

  assign raddr_v          = {raddr2, raddr1};
  assign {rdata2, rdata1} = rdata_v;
  assign {rbusy2, rbusy1} = rbusy_v;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rport
    regfile_2w_scoreboard_rport #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)
    ) u_rport (
      .raddr   (raddr_v[i]),
      .regs    (regs),
      .busy    (busy),
      .wa_en   (wr_a.en),
      .waddr_a (wr_a.addr),
      .wdata_a (wr_a.data),
      .wb_en   (wr_b.en),
      .waddr_b (wr_b.addr),
      .wdata_b (wr_b.data),
      .rdata   (rdata_v[i]),
      .rbusy   (rbusy_v[i])
    );
  end
endmodule
